// File: rtl/picorv_mem_pkg.sv
// picorv_mem_pkg: shared state encoding and constants for the PicoRV32 memory slave
package picorv_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int LAT_W = 4;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/byte_en_ram.sv
// byte_en_ram: DEPTHx32 array, byte-enabled read-before-write port plus full-word preload port
module byte_en_ram #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata
);
  logic [31:0] mem [DEPTH];
  assign a_rdata = mem[a_addr];
  // the asynchronous read above is sampled by the caller at the write edge, so it sees the old word
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
    for (int i = 0; i < 4; i++)
      if (a_we[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
  end
endmodule

// File: rtl/picorv_mem_slave.sv
// picorv_mem_slave: PicoRV32 native-interface memory with latency, range error and preload port
module picorv_mem_slave
  import picorv_mem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mem_valid,
  input  logic                     mem_instr,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               mem_wstrb,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic                     mem_err,
  input  logic                     ld_valid,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     ld_ready,
  output logic [15:0]              rd_count,
  output logic [15:0]              wr_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
  state_t state, state_nx;
  logic [LAT_W-1:0] cnt;
  logic [AW-1:0] idx_q, idx_in, a_idx;
  logic [3:0] wstrb_q, a_wstrb;
  logic [31:0] wdata_q, a_wdata, off, ram_q;
  logic inr_q, inr_in, a_inr, err_q, fire;
  logic unused;
  assign unused = ^{mem_instr, off[1:0]};
  assign off = mem_addr - ADDR_BASE;
  assign inr_in = (mem_addr >= ADDR_BASE) && (off[31:AW+2] == '0);
  assign idx_in = off[AW+1:2];
  // with LATENCY=1 the access happens on the acceptance edge, so IDLE uses the live request
  assign a_idx = state == IDLE ? idx_in : idx_q;
  assign a_wstrb = state == IDLE ? mem_wstrb : wstrb_q;
  assign a_wdata = state == IDLE ? mem_wdata : wdata_q;
  assign a_inr = state == IDLE ? inr_in : inr_q;
  assign fire = mem_valid && (state == IDLE ? LATENCY == 1 : (state == WAIT && cnt == '0));
  assign ld_ready = state == IDLE && !mem_valid;
  assign mem_ready = state == RESP;
  assign mem_err = state == RESP && err_q;
  byte_en_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .a_we   (fire && a_inr ? a_wstrb : 4'b0),
    .a_addr (a_idx),
    .a_wdata(a_wdata),
    .a_rdata(ram_q),
    .b_we   (ld_valid && ld_ready),
    .b_addr (ld_addr),
    .b_wdata(ld_data)
  );
  // next state: RESP always ends, a dropped mem_valid aborts, the access edge leads to RESP
  always_comb begin
    state_nx = state == RESP ? IDLE : !mem_valid ? IDLE : fire ? RESP : WAIT;
  end
  // state, request latch, latency countdown, response data and saturating counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      inr_q <= 1'b0;
      err_q <= 1'b0;
      mem_rdata <= '0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && mem_valid) begin
        idx_q <= idx_in;
        wstrb_q <= mem_wstrb;
        wdata_q <= mem_wdata;
        inr_q <= inr_in;
        cnt <= CNT_INIT;
      end else if (state == WAIT) cnt <= cnt - 1'b1;
      if (fire) begin
        mem_rdata <= a_inr ? ram_q : ERR_DATA;
        err_q <= !a_inr;
        if (a_inr && a_wstrb != '0 && wr_count != 16'hFFFF) wr_count <= wr_count + 1'b1;
        if (a_inr && a_wstrb == '0 && rd_count != 16'hFFFF) rd_count <= rd_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_picorv_mem_slave.sv
// tb_picorv_mem_slave: directed checks of three slaves with LATENCY 1, 4 and 3
module tb_picorv_mem_slave;
  logic clk = 1'b0;
  logic resetn;
  logic mem_valid [3], mem_instr [3], mem_ready [3], mem_err [3], ld_valid [3], ld_ready [3];
  logic [31:0] mem_addr [3], mem_wdata [3], mem_rdata [3], ld_data [3];
  logic [3:0] mem_wstrb [3];
  logic [7:0] ld_addr [3];
  logic [15:0] rd_count [3], wr_count [3];
  int checks = 0, failures = 0;
  logic [31:0] rd;
  logic er;
  int n, seen, z;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    picorv_mem_slave #(.DEPTH(256), .LATENCY(g == 0 ? 1 : (g == 1 ? 4 : 3))) dut (
      .clk      (clk),
      .resetn   (resetn),
      .mem_valid(mem_valid[g]),
      .mem_instr(mem_instr[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_wstrb(mem_wstrb[g]),
      .mem_ready(mem_ready[g]),
      .mem_rdata(mem_rdata[g]),
      .mem_err  (mem_err[g]),
      .ld_valid (ld_valid[g]),
      .ld_addr  (ld_addr[g]),
      .ld_data  (ld_data[g]),
      .ld_ready (ld_ready[g]),
      .rd_count (rd_count[g]),
      .wr_count (wr_count[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int k, input logic [7:0] a, input logic [31:0] d);
    ld_valid[k] = 1'b1;
    ld_addr[k] = a;
    ld_data[k] = d;
    #1;
    chk("ld_ready_idle", ld_ready[k], 1);
    tick();
    ld_valid[k] = 1'b0;
  endtask

  task automatic access(input int k, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] r, output logic e, output int c);
    mem_valid[k] = 1'b1;
    mem_addr[k] = a;
    mem_wstrb[k] = s;
    mem_wdata[k] = d;
    c = 0;
    do begin
      tick();
      c++;
    end while (!mem_ready[k] && c < 40);
    r = mem_rdata[k];
    e = mem_err[k];
    mem_valid[k] = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_valid[k] = 0; mem_instr[k] = 0; mem_addr[k] = 0; mem_wdata[k] = 0;
      mem_wstrb[k] = 0; ld_valid[k] = 0; ld_addr[k] = 0; ld_data[k] = 0;
    end
    tick();
    tick();
    chk("rst_ready", mem_ready[0], 0);
    chk("rst_rdata", mem_rdata[0], 0);
    chk("rst_err", mem_err[0], 0);
    chk("rst_rd_count", rd_count[0], 0);
    chk("rst_wr_count", wr_count[0], 0);
    chk("rst_ld_ready", ld_ready[0], 1);
    resetn = 1'b1;
    tick();
    // LATENCY=1 read of preloaded word 200
    preload(0, 8'd200, 32'h0102_0304);
    access(0, 32'h320, 4'h0, 32'h0, rd, er, n);
    chk("l1_latency", n, 1);
    chk("l1_rdata", rd, 32'h0102_0304);
    chk("l1_err", er, 0);
    chk("l1_rd_count", rd_count[0], 1);
    chk("l1_wr_count", wr_count[0], 0);
    // out-of-range read just past the top
    access(0, 32'h400, 4'h0, 32'h0, rd, er, n);
    chk("oob_latency", n, 1);
    chk("oob_rdata", rd, 32'hDEAD_BEEF);
    chk("oob_err", er, 1);
    chk("oob_err_after", mem_err[0], 0);
    chk("oob_rdata_hold", mem_rdata[0], 32'hDEAD_BEEF);
    chk("oob_rd_count", rd_count[0], 1);
    chk("oob_wr_count", wr_count[0], 0);
    // last in-range word
    preload(0, 8'd255, 32'hCAFE_F00D);
    access(0, 32'h3FC, 4'h0, 32'h0, rd, er, n);
    chk("top_rdata", rd, 32'hCAFE_F00D);
    chk("top_err", er, 0);
    chk("top_rd_count", rd_count[0], 2);
    // LATENCY=4 partial write, read-before-write, then read back
    preload(1, 8'd239, 32'h1112_1314);
    access(1, 32'h3BC, 4'b0101, 32'hAABB_CCDD, rd, er, n);
    chk("l4_latency", n, 4);
    chk("l4_old_word", rd, 32'h1112_1314);
    chk("l4_wr_count", wr_count[1], 1);
    access(1, 32'h3BC, 4'h0, 32'h0, rd, er, n);
    chk("l4_merged", rd, 32'h11BB_13DD);
    chk("l4_rd_count", rd_count[1], 1);
    // LATENCY=3 write aborted by dropping mem_valid
    preload(2, 8'd5, 32'h5555_5555);
    mem_valid[2] = 1'b1;
    mem_addr[2] = 32'h14;
    mem_wstrb[2] = 4'hF;
    mem_wdata[2] = 32'h0;
    tick();
    mem_valid[2] = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen += int'(mem_ready[2]);
    end
    chk("abort_no_ready", seen, 0);
    chk("abort_wr_count", wr_count[2], 0);
    access(2, 32'h14, 4'h0, 32'h0, rd, er, n);
    chk("abort_latency", n, 3);
    chk("abort_mem", rd, 32'h5555_5555);
    // preload held off by back-to-back CPU reads
    ld_valid[0] = 1'b1;
    ld_addr[0] = 8'd10;
    ld_data[0] = 32'hA5A5_0001;
    mem_valid[0] = 1'b1;
    mem_addr[0] = 32'h320;
    mem_wstrb[0] = 4'h0;
    #1;
    z = int'(ld_ready[0]);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      z += int'(ld_ready[0]);
      seen += int'(mem_ready[0]);
    end
    chk("b2b_ld_ready_low", z, 0);
    chk("b2b_pulses", seen, 3);
    chk("b2b_rd_count", rd_count[0], 5);
    mem_valid[0] = 1'b0;
    #1;
    chk("b2b_ld_ready_free", ld_ready[0], 1);
    tick();
    ld_valid[0] = 1'b0;
    access(0, 32'h28, 4'h0, 32'h0, rd, er, n);
    chk("b2b_preload_data", rd, 32'hA5A5_0001);
    chk("b2b_rd_count_after", rd_count[0], 6);
    // asynchronous reset during WAIT of a write
    preload(1, 8'd3, 32'h3333_3333);
    mem_valid[1] = 1'b1;
    mem_addr[1] = 32'h0C;
    mem_wstrb[1] = 4'hF;
    mem_wdata[1] = 32'h0;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    chk("arst_ready", mem_ready[1], 0);
    chk("arst_wr_count", wr_count[1], 0);
    chk("arst_rd_count", rd_count[1], 0);
    mem_valid[1] = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    access(1, 32'h0C, 4'h0, 32'h0, rd, er, n);
    chk("arst_latency", n, 4);
    chk("arst_mem", rd, 32'h3333_3333);
    chk("arst_rd_after", rd_count[1], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
